// File: rtl/l2_line_reader_if.sv
// L2 line reader bus: request, L1 write, per-stream response and host fill.
// slave = reader side, master = scheduler/L1/host side.
interface l2_line_reader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 8,
  parameter int NSTRMS     = 16,
  parameter int L2_NCL     = 128,
  parameter int L1_NCL     = 16,
  parameter int BEATS      = 2
);
  localparam int W   = WAYS * DATA_WIDTH;
  localparam int SW  = $clog2(NSTRMS);
  localparam int PW  = $clog2(L2_NCL);
  localparam int L1W = $clog2(L1_NCL);
  localparam int BW  = $clog2(BEATS);
  localparam int AW  = SW + PW + BW;
  localparam int LW  = SW + L1W + BW;

  logic              i_req_v;
  logic              i_req_r;
  logic [SW-1:0]     i_req_sid;
  logic [PW-1:0]     i_req_ptr;
  logic              o_wr_v;
  logic              o_wr_r;
  logic [LW-1:0]     o_wr_a;
  logic [W-1:0]      o_wr_d;
  logic [NSTRMS-1:0] o_rsp_v;
  logic [NSTRMS-1:0] o_rsp_r;
  logic              i_we;
  logic [AW-1:0]     i_wa;
  logic [W-1:0]      i_wd;

  modport slave (
    input  i_req_v, i_req_sid, i_req_ptr,
    input  o_wr_r, o_rsp_r,
    input  i_we, i_wa, i_wd,
    output i_req_r, o_wr_v, o_wr_a, o_wr_d,
    output o_rsp_v
  );

  modport master (
    output i_req_v, i_req_sid, i_req_ptr,
    output o_wr_r, o_rsp_r,
    output i_we, i_wa, i_wd,
    input  i_req_r, o_wr_v, o_wr_a, o_wr_d,
    input  o_rsp_v
  );
endinterface

// File: rtl/l2_line_reader.sv
// L2->L1 line mover: credit-gated RAM reads into an output FIFO, then a per-stream response.
// Define L2RD_PERF_CNT_EN to add the o_perf_lines/o_perf_stall counters.
module l2_line_reader #(
  parameter int DATA_WIDTH  = 64,
  parameter int WAYS        = 8,
  parameter int NSTRMS      = 16,
  parameter int L2_NCL      = 128,
  parameter int L1_NCL      = 16,
  parameter int BEATS       = 2,
  parameter int RD_LAT      = 2,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  l2_line_reader_if.slave bus
`ifdef L2RD_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_lines,
  output logic [31:0] o_perf_stall
`endif
);
  localparam int W   = WAYS * DATA_WIDTH;
  localparam int SW  = $clog2(NSTRMS);
  localparam int PW  = $clog2(L2_NCL);
  localparam int L1W = $clog2(L1_NCL);
  localparam int BW  = $clog2(BEATS);
  localparam int AW  = SW + PW + BW;
  localparam int LW  = SW + L1W + BW;
  localparam int CW  = $clog2(OFIFO_DEPTH + 1);
  localparam int FW  = $clog2(OFIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, RD, DRAIN, RSP
  } state_t;

  state_t        st;
  state_t        st_nxt;
  logic [SW-1:0] sid;
  logic [PW-1:0] ptr;
  logic [BW-1:0] beat;
  logic [CW-1:0] cred;
  logic [CW-1:0] cred_nxt;
  logic          acc;
  logic          iss;
  logic          pop;
  logic          push;
  logic          rsp_hs;
  logic          last;

  assign acc      = bus.i_req_v & bus.i_req_r;
  assign iss      = (st == RD) && (cred < CW'(OFIFO_DEPTH));
  assign pop      = bus.o_wr_v & bus.o_wr_r;
  assign rsp_hs   = (st == RSP) && bus.o_rsp_r[sid];
  assign last     = (beat == BW'(BEATS - 1));
  assign cred_nxt = cred + CW'(iss) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  // DRAIN looks at next-cycle credits so the response follows the last pop directly
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:  if (acc)              st_nxt = RD;
      RD:    if (iss && last)      st_nxt = DRAIN;
      DRAIN: if (cred_nxt == '0)   st_nxt = RSP;
      RSP:   if (rsp_hs)           st_nxt = IDLE;
      default:                     st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.i_req_r = 1'b0;
    bus.o_rsp_v = '0;
    unique case (1'b1)
      (st == IDLE): bus.i_req_r = reset_n;
      (st == RSP):  bus.o_rsp_v[sid] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sid  <= '0;
      ptr  <= '0;
      beat <= '0;
      cred <= '0;
    end else begin
      cred <= cred_nxt;
      if (acc) begin
        sid  <= bus.i_req_sid;
        ptr  <= bus.i_req_ptr;
        beat <= '0;
      end else if (iss) begin
        beat <= beat + BW'(1);
      end
    end
  end

  logic [W-1:0]      mem [2**AW];
  logic [W-1:0]      dq  [RD_LAT];
  logic [LW-1:0]     pa  [RD_LAT];
  logic [RD_LAT-1:0] pv;

  // read-first: the read samples mem before this edge's host write lands
  always_ff @(posedge clk) begin
    if (bus.i_we) mem[bus.i_wa] <= bus.i_wd;
    if (iss) dq[0] <= mem[{sid, ptr, beat}];
    pa[0] <= {sid, ptr[L1W-1:0], beat};
    for (int k = 1; k < RD_LAT; k++) begin
      dq[k] <= dq[k-1];
      pa[k] <= pa[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pv <= '0;
    end else begin
      pv[0] <= iss;
      for (int k = 1; k < RD_LAT; k++) pv[k] <= pv[k-1];
    end
  end

  assign push = pv[RD_LAT-1];

  logic [LW+W-1:0] fmem [OFIFO_DEPTH];
  logic [FW-1:0]   wp;
  logic [FW-1:0]   rp;
  logic [CW-1:0]   fcnt;

  always_ff @(posedge clk) begin
    if (push) fmem[wp] <= {pa[RD_LAT-1], dq[RD_LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (push) wp <= (wp == FW'(OFIFO_DEPTH - 1)) ? '0 : wp + FW'(1);
      if (pop)  rp <= (rp == FW'(OFIFO_DEPTH - 1)) ? '0 : rp + FW'(1);
    end
  end

  assign bus.o_wr_v = (fcnt != '0);
  assign {bus.o_wr_a, bus.o_wr_d} = fmem[rp];

`ifdef L2RD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_perf_lines <= '0;
      o_perf_stall <= '0;
    end else begin
      if (rsp_hs) o_perf_lines <= o_perf_lines + 32'd1;
      if (bus.o_wr_v && !bus.o_wr_r) o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule
